// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command stream into
// APB SETUP/ACCESS transfers and returns read data, error and timeout status.
`timescale 1ns/1ps
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              w_timeout_hit;

  // Abort condition for the current ACCESS cycle when PREADY stays low.
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_LIMIT);

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign PADDR       = r_paddr;
  assign PSELx       = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;

  // Transfer FSM with all outputs registered.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= S_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= {DATA_W{1'b0}};
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_paddr       <= {ADDR_W{1'b0}};
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_paddr     <= cmd_addr;
            r_pwrite    <= cmd_write;
            r_pwdata    <= cmd_wdata;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_state     <= S_SETUP;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= {CNT_W{1'b0}};
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // A ready slave on the limit edge still completes normally.
          if (PREADY) begin
            r_rsp_rdata   <= r_pwrite ? {DATA_W{1'b0}} : PRDATA;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else if (w_timeout_hit) begin
            r_rsp_rdata   <= {DATA_W{1'b0}};
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers checked against a per-transfer outcome model.
`timescale 1ns/1ps
module tb_apb_master;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = 8'h00;
  logic [DATA_W-1:0] cmd_wdata = 32'h0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] PADDR;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY = 1'b0;
  logic [DATA_W-1:0] PRDATA = 32'h0;
  logic              PSLVERR = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired, vectors=%0d miscompares=%0d", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  // One complete transfer; must be called at a falling edge while the DUT idles.
  task automatic run_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic err, input int waits,
                          input int rdelay, input string tag);
    bit          timed;
    int          n_acc;
    int          guard;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [44:0] got_a, exp_a;
    logic [78:0] got_r, exp_r;
    logic [43:0] got_i, exp_i;
    // Outcome from the protocol rules, not from any state machine.
    timed   = (TIMEOUT != 0) && (waits >= TIMEOUT);
    n_acc   = timed ? TIMEOUT : waits + 1;
    e_rdata = (timed || wr) ? 32'h0 : rd;
    e_err   = timed || err;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge PCLK);
      guard++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept cmd_ready got %b exp 1", tag, cmd_ready);
    end
    @(posedge PCLK);
    #1 cmd_valid = 1'b0; cmd_write = 1'($urandom()); cmd_addr = 8'($urandom()); cmd_wdata = $urandom();

    @(negedge PCLK);
    got_a = {cmd_ready, PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid};
    exp_a = {1'b0, 1'b1, 1'b0, wr, addr, wd, 1'b0};
    n_vec++;
    if (got_a !== exp_a) begin
      n_fail++;
      $display("FAIL %s_setup got %h exp %h", tag, got_a, exp_a);
    end
    @(posedge PCLK);

    for (int i = 0; i < n_acc; i++) begin
      #1;
      PREADY  = (i == waits);
      PSLVERR = (i == waits) ? err : 1'($urandom());
      PRDATA  = (i == waits) ? rd : $urandom();
      @(negedge PCLK);
      got_a = {cmd_ready, PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid};
      exp_a = {1'b0, 1'b1, 1'b1, wr, addr, wd, 1'b0};
      n_vec++;
      if (got_a !== exp_a) begin
        n_fail++;
        $display("FAIL %s_access%0d got %h exp %h", tag, i, got_a, exp_a);
      end
      @(posedge PCLK);
    end

    #1 PREADY = 1'b0; PSLVERR = 1'($urandom()); PRDATA = $urandom(); cmd_valid = 1'b1;
    for (int j = 0; j <= rdelay; j++) begin
      rsp_ready = (j == rdelay);
      @(negedge PCLK);
      got_r = {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, PSELx, PENABLE, PADDR, PWRITE, PWDATA};
      exp_r = {1'b1, e_rdata, e_err, timed, 1'b0, 1'b0, 1'b0, addr, wr, wd};
      n_vec++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL %s_resp%0d got %h exp %h", tag, j, got_r, exp_r);
      end
      @(posedge PCLK);
      #1;
    end
    rsp_ready = 1'b0; cmd_valid = 1'b0;

    @(negedge PCLK);
    got_i = {rsp_valid, cmd_ready, PSELx, PENABLE, PADDR, PWRITE, PWDATA};
    exp_i = {1'b0, 1'b1, 1'b0, 1'b0, addr, wr, wd};
    n_vec++;
    if (got_i !== exp_i) begin
      n_fail++;
      $display("FAIL %s_idle got %h exp %h", tag, got_i, exp_i);
    end
  endtask

  task automatic test_reset();
    logic [80:0] v;
    #3;
    v = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PSELx, PENABLE, PWRITE, PWDATA};
    n_vec++;
    if (v !== 81'h0) begin
      n_fail++;
      $display("FAIL reset_values got %h exp 0", v);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_noedge cmd_ready got %b exp 0", cmd_ready);
    end
    @(negedge PCLK);
    n_vec++;
    if ({cmd_ready, rsp_valid, PSELx} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_first_edge got %b exp 100", {cmd_ready, rsp_valid, PSELx});
    end
  endtask

  task automatic test_write_zero_wait();
    run_xfer(1'b1, 8'h10, 32'hDEADBEEF, 32'h5555AAAA, 1'b0, 0, 0, "write0");
  endtask

  task automatic test_read_waits();
    run_xfer(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, "read_wait3");
  endtask

  task automatic test_slverr();
    run_xfer(1'b0, 8'h24, 32'h0, 32'h00001234, 1'b1, 0, 0, "slverr");
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 8'h30, 32'h0, 32'hCAFEF00D, 1'b0, 40, 0, "timeout");
    run_xfer(1'b0, 8'h31, 32'h0, 32'hCAFEF00D, 1'b0, TIMEOUT - 1, 0, "limit_ready");
    run_xfer(1'b1, 8'h32, 32'h0BADF00D, 32'h0, 1'b0, TIMEOUT, 1, "limit_miss");
  endtask

  task automatic test_backpressure();
    run_xfer(1'b0, 8'hA5, 32'h11112222, 32'h87654321, 1'b0, 1, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b1, 8'h01, 32'h00000001, 32'h0, 1'b0, 0, 0, "b2b_a");
    run_xfer(1'b0, 8'h02, 32'h0, 32'hFFFFFFFF, 1'b0, 0, 0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    logic [80:0] v;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_wdata = 32'h44444444;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(posedge PCLK);
    #1 PREADY = 1'b0;
    @(negedge PCLK);
    n_vec++;
    if ({PSELx, PENABLE} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_in_access got %b exp 11", {PSELx, PENABLE});
    end
    #2 PRESETn = 1'b0;
    #1;
    v = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PSELx, PENABLE, PWRITE, PWDATA};
    n_vec++;
    if (v !== 81'h0) begin
      n_fail++;
      $display("FAIL rstmid_async got %h exp 0", v);
    end
    PREADY = 1'b1; PRDATA = $urandom(); rsp_ready = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1 PREADY = 1'b0;
    @(negedge PCLK);
    n_vec++;
    if ({cmd_ready, rsp_valid, PSELx, PENABLE} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rstmid_release got %b exp 1000", {cmd_ready, rsp_valid, PSELx, PENABLE});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      n_vec++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_no_rsp%0d rsp_valid got %b exp 0", k, rsp_valid);
      end
    end
    rsp_ready = 1'b0;
    run_xfer(1'b0, 8'h45, 32'h0, 32'h13579BDF, 1'b0, 2, 0, "after_reset");
  endtask

  task automatic test_random();
    logic        wr;
    logic        err;
    logic [7:0]  addr;
    logic [31:0] wd, rd;
    int          waits, rdelay;
    for (int n = 0; n < 25; n++) begin
      wr     = 1'($urandom());
      err    = ($urandom_range(0, 3) == 0);
      addr   = 8'($urandom());
      wd     = $urandom();
      rd     = $urandom();
      waits  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      rdelay = int'($urandom_range(0, 3));
      run_xfer(wr, addr, wd, rd, err, waits, rdelay, "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
